// File: rtl/dec_7seg_scan4.sv
`default_nettype none
// ============================================================================
// Module  : dec_7seg_scan4
// Brief   : 4-digit multiplexed BCD scanner for a common-anode display.
//           Drives one nibble per refresh slot into dec_7seg.
// Revision: 1.0
// ============================================================================
module dec_7seg_scan4 #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int LZB         = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic [3:0]  digit_out,
  output logic [3:0]  an_n,
  output logic        frame_start,
  output logic        load_ack
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] C_BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [DIV_W-1:0] C_DIV_ONE   = DIV_W'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sel_q, sel_d;
  logic             run_q, run_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic [3:0]       digit_out_q, digit_out_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             frame_start_q, frame_start_d;
  logic             load_ack_q, load_ack_d;

  logic             frame_edge;
  logic [3:0]       lead_zero;
  logic [3:0]       nibble;

  // Slot counters; run_q holds the scan at slot-cycle 0 for the first
  // cycle after reset so that cycle is the frame boundary.
  always_comb begin
    run_d = 1'b1;
    div_d = div_q;
    sel_d = sel_q;
    if (!run_q) begin
      div_d = '0;
      sel_d = 2'd0;
    end else if (div_q == C_DIV_LAST) begin
      div_d = '0;
      sel_d = sel_q + 2'd1;
    end else begin
      div_d = div_q + C_DIV_ONE;
    end
    frame_edge = (div_d == '0) && (sel_d == 2'd0);
  end

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    if (frame_edge) begin
      if (load) begin
        shadow_d   = digits_in;
        active_d   = digits_in;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (pending_q) begin
        active_d   = shadow_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (div_d >= C_BLANK_END) state_d = ST_ON;
      ST_ON:    if (div_d <  C_BLANK_END) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Outputs are computed from next-state values so the registered copies
  // line up with the slot-cycle they describe.
  always_comb begin
    lead_zero[3] = (active_d[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (active_d[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (active_d[7:4] == 4'h0);
    lead_zero[0] = 1'b0;
    case (sel_d)
      2'd0:    nibble = active_d[3:0];
      2'd1:    nibble = active_d[7:4];
      2'd2:    nibble = active_d[11:8];
      default: nibble = active_d[15:12];
    endcase
    digit_out_d   = 4'hF;
    an_n_d        = 4'b1111;
    frame_start_d = frame_edge;
    if (state_d == ST_ON) begin
      an_n_d      = ~(4'b0001 << sel_d);
      digit_out_d = ((LZB != 0) && lead_zero[sel_d]) ? 4'hF : nibble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      div_q         <= '0;
      sel_q         <= 2'd0;
      run_q         <= 1'b0;
      shadow_q      <= 16'h0000;
      active_q      <= 16'h0000;
      pending_q     <= 1'b0;
      digit_out_q   <= 4'hF;
      an_n_q        <= 4'b1111;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sel_q         <= sel_d;
      run_q         <= run_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      digit_out_q   <= digit_out_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign digit_out   = digit_out_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;
  assign load_ack    = load_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_7seg_scan4.sv
`default_nettype none
// ============================================================================
// Module  : tb_dec_7seg_scan4
// Brief   : Scoreboard bench for dec_7seg_scan4 (LZB=1 and LZB=0 instances).
// Revision: 1.0
// ============================================================================
module tb_dec_7seg_scan4;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;

  logic [3:0] digit_out1, an_n1, digit_out0, an_n0;
  logic       frame_start1, load_ack1, frame_start0, load_ack0;

  dec_7seg_scan4 #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK), .LZB(1)) dut_lzb (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .digit_out(digit_out1), .an_n(an_n1),
    .frame_start(frame_start1), .load_ack(load_ack1)
  );

  dec_7seg_scan4 #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK), .LZB(0)) dut_nolzb (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .digit_out(digit_out0), .an_n(an_n0),
    .frame_start(frame_start0), .load_ack(load_ack0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic       fs;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: a cycle index since reset release and the frame rules.
  bit          m_started = 1'b0;
  int          m_t = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  bit          m_pending = 1'b0;

  function automatic logic [3:0] ref_digit(logic [15:0] act, int slot, bit lzb);
    int a;
    a = int'(act);
    if (lzb && slot > 0 && (a >> (4 * slot)) == 0) return 4'hF;
    return 4'((a >> (4 * slot)) % 16);
  endfunction

  function automatic int next_pos();
    return m_started ? (m_t + 1) % FRAME : 0;
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic [15:0] d);
    exp_t e;
    int   pos, slot, k;
    e.an = 4'hF; e.dig1 = 4'hF; e.dig0 = 4'hF; e.fs = 1'b0; e.ack = 1'b0;
    if (r) begin
      m_started = 1'b0; m_t = 0;
      m_active = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
    end else begin
      if (m_started) m_t = m_t + 1;
      else begin m_started = 1'b1; m_t = 0; end
      pos  = m_t % FRAME;
      slot = pos / DIV;
      k    = pos % DIV;
      if (pos == 0) begin
        if (l) begin
          m_active = d; m_shadow = d; m_pending = 1'b0; e.ack = 1'b1;
        end else if (m_pending) begin
          m_active = m_shadow; m_pending = 1'b0; e.ack = 1'b1;
        end
      end else if (l) begin
        m_shadow = d; m_pending = 1'b1;
      end
      e.fs = (pos == 0);
      if (k >= BLK) begin
        e.an   = 4'(15 - (1 << slot));
        e.dig1 = ref_digit(m_active, slot, 1'b1);
        e.dig0 = ref_digit(m_active, slot, 1'b0);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] d);
    rst = r; load = l; digits_in = d;
    @(posedge clk);
    model_edge(r, l, d);
    #1;
  endtask

  task automatic idle_until(input int p);
    for (int i = 0; i < FRAME + 1 && next_pos() != p; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an_n_lzb1",        an_n1,               e.an);
      check("digit_out_lzb1",   digit_out1,          e.dig1);
      check("frame_start_lzb1", {3'b0, frame_start1}, {3'b0, e.fs});
      check("load_ack_lzb1",    {3'b0, load_ack1},    {3'b0, e.ack});
      check("an_n_lzb0",        an_n0,               e.an);
      check("digit_out_lzb0",   digit_out0,          e.dig0);
      check("frame_start_lzb0", {3'b0, frame_start0}, {3'b0, e.fs});
      check("load_ack_lzb0",    {3'b0, load_ack0},    {3'b0, e.ack});
    end
  end

  initial begin
    logic [15:0] rd;
    // Reset, then run the first frame with active = 0.
    step(1'b1, 1'b0, 16'h0); step(1'b1, 1'b1, 16'hBEEF); step(1'b1, 1'b0, 16'h0);
    idle(10);
    step(1'b0, 1'b1, 16'h1234);
    idle_until(4);
    // Reset during the slot-2 ON window with 1234 active.
    idle_until(2 * DIV + 4);
    step(1'b1, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    idle(FRAME + 4);
    // Leading-zero blanking patterns.
    step(1'b0, 1'b1, 16'h0070); idle_until(1); idle(FRAME);
    step(1'b0, 1'b1, 16'h00A5); idle_until(1); idle(FRAME);
    step(1'b0, 1'b1, 16'h0F00); idle_until(1); idle(FRAME);
    // Load on the boundary edge itself.
    idle_until(0);
    step(1'b0, 1'b1, 16'h9999); idle(FRAME);
    // Two loads in one frame: last wins, single ack.
    idle_until(5);
    step(1'b0, 1'b1, 16'h1111); idle(6);
    step(1'b0, 1'b1, 16'h2222); idle_until(1); idle(FRAME);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rd = 16'h0;
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 2) != 0) rd[4*n +: 4] = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 14) == 0), rd);
    end
    idle(2);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec_7seg_scan4.md
Name: dec_7seg_scan4

Overview:
- Four-digit multiplexed scanner that sits directly upstream of the dec_7seg decoder in the display path.
- Holds a double-buffered 4-digit BCD word and time-multiplexes one nibble per refresh slot onto the decoder input.
- Drives active-low common-anode digit enables, with an inter-digit blanking guard against ghosting and optional leading-zero blanking.
- A nibble value of 4'hF is the blank code; dec_7seg maps it to all segments off.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (50 MHz gives 1 kHz per digit); must be >= 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- LZB, 1: 1 enables leading-zero blanking; 0 disables it.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- load, in, 1: single-cycle strobe; capture digits_in into the shadow register.
- digits_in, in, 16: [15:12] digit3 (leftmost) through [3:0] digit0 (rightmost).
- digit_out, out, 4: nibble to the dec_7seg in port; 4'hF = blank.
- an_n, out, 4: active-low anode enables; an_n[i] enables digit i.
- frame_start, out, 1: one-cycle pulse on slot-cycle 0 of the digit-0 slot.
- load_ack, out, 1: one-cycle pulse when the active register takes a new value.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Registers:
  - div: 0..REFRESH_DIV-1, wraps to 0.
  - sel: 0..3, increments when div wraps; wraps 3->0.
  - shadow[15:0], active[15:0], pending.
- All outputs are registered. "Slot-cycle k" means div==k; output values below are those held during that cycle.
- Per-slot FSM, two states:
  - BLANK (k < BLANK_CYC): an_n=4'b1111, digit_out=4'hF.
  - ON (k >= BLANK_CYC): an_n has a single 0 at bit sel; digit_out = displayed nibble sel.
  - BLANK->ON at k=BLANK_CYC; ON->BLANK at div wrap.
- Scan order: sel 0,1,2,3. Anodes 1110,1101,1011,0111. Frame = 4*REFRESH_DIV cycles.
- Load:
  - load=1 writes digits_in to shadow and sets pending.
  - Multiple loads within a frame: the last one wins; one ack per frame.
- Frame boundary (div==0, sel==0):
  - If pending, active<=shadow, pending<=0, load_ack=1 that cycle.
  - If load coincides with the boundary, digits_in goes straight to active, pending=0, load_ack=1.
  - active never changes mid-frame.
- Leading-zero blanking (LZB=1):
  - Digit i (i=3,2,1) shows 4'hF when active digit i and all higher digits are 4'h0.
  - Digit 0 is never blanked.
  - Any nonzero nibble, including non-BCD A-F, stops blanking.
  - LZB=0 passes all nibbles unchanged.
- Non-BCD nibbles pass through unmodified; the decoder blanks them.
- Reset values (the cycle after rst sampled high): div=0, sel=0, shadow=0, active=0, pending=0, an_n=4'b1111, digit_out=4'hF, frame_start=0, load_ack=0.
- After reset release, the first cycle is slot-cycle 0 of digit 0 in BLANK, with frame_start=1.
- rst overrides load and any mid-slot state; a load coinciding with rst is discarded.

Test Plan:
(All with REFRESH_DIV=8, BLANK_CYC=2, LZB=1 unless stated.)
- Reset sequence:
  - rst high for 3 cycles -> an_n=1111, digit_out=F, load_ack=0.
  - After release: frame_start=1 at cycle 0; cycles 0-1 an_n=1111.
  - Cycles 2-7: an_n=1110, digit_out=0.
  - Slots 1-3: digit_out=F with an_n=1101/1011/0111.
- Deferred load:
  - load 16'h1234 at frame cycle 10 -> display unchanged until next frame_start at cycle 32, where load_ack=1.
  - Then ON windows show 4,3,2,1 on an_n 1110,1101,1011,0111.
- Leading-zero blanking:
  - active=16'h0070 -> digits 0..3 show 0,7,F,F.
  - Same value with LZB=0 -> 0,7,0,0.
  - active=16'h00A5 -> 5,A,F,F.
- Load/boundary collisions:
  - load 16'h9999 exactly on the frame-boundary cycle -> load_ack that cycle; 9 shown in slot 0 of the same frame.
  - Two loads (16'h1111 then 16'h2222) in one frame -> one ack; 2222 displayed.
- Reset mid-operation:
  - Assert rst during the slot-2 ON window with active=16'h1234 -> next cycle an_n=1111, digit_out=F.
  - Post-release, the display shows 0 on digit 0 only; no load_ack.
